aes_cipher_core: RTL and testbench

- Iterative AES block encryption core supporting AES-128/192/256, with key length selected at runtime through nk.
- Adds a valid/ready streaming interface, back-to-back block processing, CBC chaining, output backpressure and error/abort handling.
- Sits between the keyexpansion block and the system datapath. Consumes the expanded key bus w plus the keyexpansion done/err flags. Performs one round per clock.

---
 rtl/aes_cipher_core.sv | 180 ++++++++++++++++++
 tb/tb_aes_cipher_core.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_cipher_core.sv
`default_nettype none
// ============================================================================
// Module : aes_cipher_core
// Iterative AES-128/192/256 encryptor, one round per clock, ECB or CBC chaining.
// Rev    : 1.0  initial release
// ============================================================================
module aes_cipher_core #(
  parameter int NR_MAX  = 14,
  parameter int W_WIDTH = 128*(NR_MAX+1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         nk,
  input  logic [W_WIDTH-1:0] w,
  input  logic               key_valid,
  input  logic               key_err,
  input  logic               cbc_en,
  input  logic               iv_load,
  input  logic [127:0]       iv,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [127:0]       in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [127:0]       out_data,
  output logic               busy,
  output logic               err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t       r_state, w_state_nxt;
  logic [3:0]   r_round, r_nr;
  logic         r_cbc, r_err, w_err_nxt;
  logic [127:0] r_chain, r_data, r_out;
  logic [127:0] w_rk [NR_MAX+1];
  logic [127:0] w_chain_sel, w_round_out;
  logic         w_nk_ok, w_in_rdy, w_accept, w_abort, w_last;

  function automatic logic [7:0] f_xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] f_gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = f_xtime(t);
    end
    return p;
  endfunction

  // Inverse as x^254 via an addition chain, then the affine transform.
  function automatic logic [7:0] f_sbox(input logic [7:0] x);
    logic [7:0] x2, x3, x12, x14, x15, x240, inv;
    x2   = f_gmul(x, x);
    x3   = f_gmul(x2, x);
    x12  = f_gmul(x3, x3);
    x12  = f_gmul(x12, x12);
    x14  = f_gmul(x12, x2);
    x15  = f_gmul(x12, x3);
    x240 = f_gmul(x15, x15);
    x240 = f_gmul(x240, x240);
    x240 = f_gmul(x240, x240);
    x240 = f_gmul(x240, x240);
    inv  = f_gmul(x240, x14);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] f_round(input logic [127:0] s, input logic mix);
    logic [7:0]   b  [16];
    logic [7:0]   sr [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] r;
    for (int i = 0; i < 16; i++) b[i] = f_sbox(s[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int rr = 0; rr < 4; rr++)
        sr[rr+4*c] = b[rr + 4*((c+rr)%4)];
    for (int c = 0; c < 4; c++) begin
      a0 = sr[4*c]; a1 = sr[4*c+1]; a2 = sr[4*c+2]; a3 = sr[4*c+3];
      if (mix)
        r[127-32*c -: 32] = {f_xtime(a0) ^ f_xtime(a1) ^ a1 ^ a2 ^ a3,
                             a0 ^ f_xtime(a1) ^ f_xtime(a2) ^ a2 ^ a3,
                             a0 ^ a1 ^ f_xtime(a2) ^ f_xtime(a3) ^ a3,
                             f_xtime(a0) ^ a0 ^ a1 ^ a2 ^ f_xtime(a3)};
      else
        r[127-32*c -: 32] = {a0, a1, a2, a3};
    end
    return r;
  endfunction

  for (genvar g = 0; g <= NR_MAX; g++) begin : g_rk
    assign w_rk[g] = w[W_WIDTH-1-128*g -: 128];
  end

  assign w_nk_ok     = (nk == 4'd4) || (nk == 4'd6) || (nk == 4'd8);
  assign w_in_rdy    = (r_state == S_IDLE) && key_valid && !key_err && w_nk_ok;
  assign w_accept    = w_in_rdy && in_valid;
  assign w_abort     = (r_state == S_ROUND) && (!key_valid || key_err);
  assign w_last      = (r_round == r_nr);
  assign w_chain_sel = iv_load ? iv : r_chain;
  assign w_round_out = f_round(r_data, !w_last) ^ w_rk[r_round];

  assign in_ready  = w_in_rdy;
  assign out_valid = (r_state == S_HOLD);
  assign out_data  = r_out;
  assign busy      = (r_state != S_IDLE);
  assign err       = r_err;

  always_comb begin
    w_state_nxt = r_state;
    w_err_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept)                   w_state_nxt = S_ROUND;
        else if (in_valid && !w_nk_ok)  w_err_nxt   = 1'b1;
      end
      S_ROUND: begin
        if (w_abort) begin
          w_state_nxt = S_IDLE;
          w_err_nxt   = 1'b1;
        end else if (w_last) begin
          w_state_nxt = S_HOLD;
        end
      end
      S_HOLD:  if (out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_round <= 4'd0;
      r_nr    <= 4'd0;
      r_cbc   <= 1'b0;
      r_err   <= 1'b0;
      r_chain <= '0;
      r_data  <= '0;
      r_out   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_err   <= w_err_nxt;
      case (r_state)
        S_IDLE: begin
          if (iv_load) r_chain <= iv;
          if (w_accept) begin
            r_nr    <= nk + 4'd6;
            r_cbc   <= cbc_en;
            r_data  <= in_data ^ (cbc_en ? w_chain_sel : 128'h0) ^ w_rk[0];
            r_round <= 4'd1;
          end
        end
        S_ROUND: begin
          if (w_abort) begin
            r_round <= 4'd0;
          end else if (w_last) begin
            r_out   <= w_round_out;
            r_round <= 4'd0;
          end else begin
            r_data  <= w_round_out;
            r_round <= r_round + 4'd1;
          end
        end
        S_HOLD: if (out_ready && r_cbc) r_chain <= r_out;
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_aes_cipher_core.sv
`default_nettype none
// ============================================================================
// Module : tb_aes_cipher_core
// Self-checking bench: known-answer vectors, CBC, backpressure, errors, random.
// Rev    : 1.0  initial release
// ============================================================================
module tb_aes_cipher_core;
  localparam int NR_MAX  = 14;
  localparam int W_WIDTH = 128*(NR_MAX+1);
  localparam logic [255:0] KEY    = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KAT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KAT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] KAT256 = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic               clk = 1'b0;
  logic               rst;
  logic [3:0]         nk;
  logic [W_WIDTH-1:0] w;
  logic               key_valid, key_err, cbc_en, iv_load;
  logic [127:0]       iv;
  logic               in_valid, in_ready;
  logic [127:0]       in_data;
  logic               out_valid, out_ready;
  logic [127:0]       out_data;
  logic               busy, err;

  int           n_checks = 0;
  int           n_errors = 0;
  logic [7:0]   m_sbox [256];
  logic [127:0] m_chain;
  logic         saw;

  always #5 clk = ~clk;

  aes_cipher_core #(.NR_MAX(NR_MAX), .W_WIDTH(W_WIDTH)) dut (
    .clk(clk), .rst(rst), .nk(nk), .w(w), .key_valid(key_valid), .key_err(key_err),
    .cbc_en(cbc_en), .iv_load(iv_load), .iv(iv), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .err(err)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] m_gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    while (bb != 8'h00) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
      bb = bb >> 1;
    end
    return p;
  endfunction

  // S-box by brute-force inverse search and the bitwise affine formula.
  task automatic m_build_sbox();
    logic [7:0] inv, s, c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (m_gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      m_sbox[x] = s;
    end
  endtask

  function automatic logic [31:0] m_subw(input logic [31:0] x);
    return {m_sbox[x[31:24]], m_sbox[x[23:16]], m_sbox[x[15:8]], m_sbox[x[7:0]]};
  endfunction

  function automatic logic [W_WIDTH-1:0] m_expand(input logic [255:0] key, input int nkw);
    logic [31:0]        wd [60];
    logic [31:0]        t;
    logic [7:0]         rc;
    logic [W_WIDTH-1:0] bus;
    int                 nwords;
    nwords = 4*(nkw+7);
    rc     = 8'h01;
    bus    = '0;
    for (int i = 0; i < 60; i++) wd[i] = 32'h0;
    for (int i = 0; i < nkw; i++) wd[i] = key[255-32*i -: 32];
    for (int i = nkw; i < nwords; i++) begin
      t = wd[i-1];
      if (i % nkw == 0) begin
        t  = m_subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = m_gmul(rc, 8'h02);
      end else if (nkw > 6 && i % nkw == 4) begin
        t = m_subw(t);
      end
      wd[i] = wd[i-nkw] ^ t;
    end
    for (int i = 0; i < nwords; i++) bus[W_WIDTH-1-32*i -: 32] = wd[i];
    return bus;
  endfunction

  function automatic logic [127:0] m_encrypt(input logic [127:0] pt, input logic [W_WIDTH-1:0] wb,
                                             input int nkw);
    logic [7:0]   s [4][4];
    logic [7:0]   t [4][4];
    logic [127:0] res;
    int           nr;
    nr = nkw + 6;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        s[r][c] = pt[127-8*(r+4*c) -: 8] ^ wb[W_WIDTH-1-8*(r+4*c) -: 8];
    for (int rnd = 1; rnd <= nr; rnd++) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          t[r][c] = m_sbox[s[r][(c+r)%4]];
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) begin
          if (rnd != nr)
            s[r][c] = m_gmul(8'h02, t[r][c]) ^ m_gmul(8'h03, t[(r+1)%4][c]) ^
                      t[(r+2)%4][c] ^ t[(r+3)%4][c];
          else
            s[r][c] = t[r][c];
          s[r][c] = s[r][c] ^ wb[W_WIDTH-1-128*rnd-8*(r+4*c) -: 8];
        end
    end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        res[127-8*(r+4*c) -: 8] = s[r][c];
    return res;
  endfunction

  // One full block: accept, latency, optional output stall, handshake.
  task automatic send_block(input string tag, input logic [3:0] knk, input logic [127:0] pt,
                            input logic cbc, input logic ivl, input logic [127:0] ivv,
                            input int stall, input logic [127:0] kat, input logic use_kat);
    logic [127:0] exp, held;
    int           cnt;
    if (ivl) m_chain = ivv;
    exp = use_kat ? kat : m_encrypt(pt ^ (cbc ? m_chain : 128'h0), w, int'(knk));
    @(posedge clk); #1;
    nk = knk; cbc_en = cbc; in_data = pt; in_valid = 1'b1; iv_load = ivl; iv = ivv;
    #1 check({tag, "/in_ready"}, 128'(in_ready), 128'(1));
    @(posedge clk); #1;
    in_valid = 1'b0; iv_load = 1'b0;
    nk = 4'($urandom_range(0, 15)); cbc_en = 1'($urandom); in_data = {4{$urandom}};
    cnt = 0;
    while (!out_valid && cnt < 40) begin
      @(posedge clk); #1;
      cnt++;
    end
    check({tag, "/latency"}, 128'(cnt), 128'(knk + 4'd6));
    held = out_data;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      check({tag, "/stall_valid"}, 128'(out_valid), 128'(1));
      check({tag, "/stall_data"}, out_data, held);
      check({tag, "/stall_in_ready"}, 128'(in_ready), 128'(0));
    end
    nk = knk; out_ready = 1'b1;
    #1 check({tag, "/data"}, out_data, exp);
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "/valid_drop"}, 128'(out_valid), 128'(0));
    check({tag, "/in_ready_after"}, 128'(in_ready), 128'(1));
    if (cbc) m_chain = exp;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    m_build_sbox();
    rst = 1'b1; nk = 4'd4; w = '0; key_valid = 1'b0; key_err = 1'b0; cbc_en = 1'b0;
    iv_load = 1'b0; iv = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; m_chain = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst/out_valid", 128'(out_valid), 128'(0));
    check("rst/out_data", out_data, 128'h0);
    check("rst/err", 128'(err), 128'(0));
    check("rst/busy", 128'(busy), 128'(0));
    check("rst/in_ready", 128'(in_ready), 128'(0));
    rst = 1'b0;

    key_valid = 1'b1;
    w = m_expand(KEY, 4);
    send_block("kat128", 4'd4, PT, 1'b0, 1'b0, 128'h0, 0, KAT128, 1'b1);
    w = m_expand(KEY, 6);
    send_block("kat192", 4'd6, PT, 1'b0, 1'b0, 128'h0, 0, KAT192, 1'b1);
    w = m_expand(KEY, 8);
    send_block("kat256", 4'd8, PT, 1'b0, 1'b0, 128'h0, 0, KAT256, 1'b1);

    w = m_expand(KEY, 4);
    @(posedge clk); #1 iv_load = 1'b1; iv = 128'h0;
    @(posedge clk); #1 iv_load = 1'b0;
    m_chain = 128'h0;
    send_block("cbc1", 4'd4, PT, 1'b1, 1'b0, 128'h0, 5, KAT128, 1'b1);
    send_block("cbc2", 4'd4, PT, 1'b1, 1'b0, 128'h0, 0, 128'h0, 1'b0);
    send_block("cbc3", 4'd4, PT, 1'b1, 1'b1, 128'h0, 0, KAT128, 1'b1);

    @(posedge clk); #1 nk = 4'd5; in_data = PT; in_valid = 1'b1;
    #1 check("nk5/in_ready", 128'(in_ready), 128'(0));
    @(posedge clk); #1;
    check("nk5/err", 128'(err), 128'(1));
    check("nk5/busy", 128'(busy), 128'(0));
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("nk5/err_pulse", 128'(err), 128'(0));
    check("nk5/out_valid", 128'(out_valid), 128'(0));

    nk = 4'd4; cbc_en = 1'b1; in_data = PT; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 key_valid = 1'b0;
    @(posedge clk); #1;
    check("abort/err", 128'(err), 128'(1));
    check("abort/busy", 128'(busy), 128'(0));
    saw = 1'b0;
    repeat (16) begin
      @(posedge clk); #1;
      if (out_valid) saw = 1'b1;
    end
    check("abort/no_output", 128'(saw), 128'(0));
    key_valid = 1'b1;
    send_block("post_abort_cbc", 4'd4, PT, 1'b1, 1'b0, 128'h0, 0, 128'h0, 1'b0);

    @(posedge clk); #1;
    w = m_expand(KEY, 8); nk = 4'd8; cbc_en = 1'b0; in_data = PT; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    check("midrst/out_valid", 128'(out_valid), 128'(0));
    check("midrst/busy", 128'(busy), 128'(0));
    check("midrst/out_data", out_data, 128'h0);
    rst = 1'b0;
    m_chain = 128'h0;
    send_block("post_rst", 4'd8, PT, 1'b0, 1'b0, 128'h0, 0, KAT256, 1'b1);
    send_block("post_rst_cbc", 4'd8, PT, 1'b1, 1'b0, 128'h0, 0, KAT256, 1'b1);

    for (int n = 0; n < 10; n++) begin
      logic [255:0] k;
      int           kn;
      k  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      kn = 4 + 2*$urandom_range(0, 2);
      w  = m_expand(k, kn);
      send_block($sformatf("rnd%0d", n), 4'(kn), {$urandom, $urandom, $urandom, $urandom},
                 1'($urandom), 1'($urandom_range(0, 3) == 0),
                 {$urandom, $urandom, $urandom, $urandom}, $urandom_range(0, 3), 128'h0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire
